// File: rtl/sn_stream_decoder.sv
// sn_stream_decoder
// Converts a serial stochastic bitstream into a binary value by counting
// ones over back-to-back windows of 2^WIN_LOG2 valid bits. Each finished
// window produces one result on a single-entry output register. The
// register raises a sticky overrun flag if a result is overwritten before
// the consumer takes it. Both unipolar and bipolar decoding are supported.
//
// Output handshake: out_valid = 1 means out_data holds a result that has
// not been consumed yet. A transfer happens on every rising edge where
// out_valid & out_ready are both 1. out_data stays stable while out_valid
// is 1, unless a newer window result overwrites it; that overwrite also
// sets overrun. Once out_valid is 1, it only drops after a transfer.
//
// Reset is asynchronous and active-high. The port keeps its historical
// name rst_n, but rst_n = 1 means reset.

module sn_stream_decoder #(
  parameter int WIN_LOG2 = 8,   // log2 of window length in valid bits, 2..16
  parameter int OUT_W    = 8    // result width, 2..WIN_LOG2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             sn_bit,
  input  logic             sn_valid,
  input  logic             bipolar,
  output logic [OUT_W-1:0] out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic [0:0]       o_dbg_state
);

  // FSM encoding
  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  // Right shift that maps a WIN_LOG2-bit count onto an OUT_W-bit result
  localparam int SH = WIN_LOG2 - OUT_W;

  localparam logic [WIN_LOG2-1:0] BIT_ONE = {{(WIN_LOG2-1){1'b0}}, 1'b1};
  localparam logic [WIN_LOG2-1:0] BIT_MAX = {WIN_LOG2{1'b1}};

  // Bipolar constants are held at WIN_LOG2+2 bits. That width covers
  // +/- N/2 with a sign bit and some headroom.
  localparam logic signed [WIN_LOG2+1:0] HALF =
    {2'b00, 1'b1, {(WIN_LOG2-1){1'b0}}};
  localparam logic signed [WIN_LOG2+1:0] BMAX =
    {{(WIN_LOG2+3-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [WIN_LOG2+1:0] BMIN =
    {{(WIN_LOG2+3-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic [0:0]          r_state;
  logic [WIN_LOG2-1:0] r_bit_cnt;
  logic [WIN_LOG2:0]   r_ones_cnt;
  logic                r_mode;
  logic [OUT_W-1:0]    r_out_data;
  logic                r_out_valid;
  logic                r_overrun;

  logic                       w_last;
  logic [WIN_LOG2:0]          w_total;
  logic [OUT_W:0]             w_u;
  logic signed [WIN_LOG2+1:0] w_s;
  logic signed [WIN_LOG2+1:0] w_r;
  logic [OUT_W-1:0]           w_result;

  // Window end: the Nth valid bit of the window is being sampled now.
  assign w_last = (r_state == S_COUNT) && en && sn_valid && (r_bit_cnt == BIT_MAX);

  // Running count including the current bit. At window end this is the total.
  assign w_total = r_ones_cnt + {{WIN_LOG2{1'b0}}, sn_bit};

  // Decode the total according to the mode latched at window start.
  always_comb begin
    w_u      = w_total[WIN_LOG2:SH];
    w_s      = $signed({1'b0, w_total}) - HALF;
    w_r      = w_s >>> SH;
    w_result = '0;
    if (!r_mode) begin
      // Only an all-ones window reaches 2^OUT_W; saturate it.
      if (w_u[OUT_W]) begin
        w_result = {OUT_W{1'b1}};
      end else begin
        w_result = w_u[OUT_W-1:0];
      end
    end else begin
      if (w_r > BMAX) begin
        w_result = BMAX[OUT_W-1:0];
      end else if (w_r < BMIN) begin
        w_result = BMIN[OUT_W-1:0];
      end else begin
        w_result = w_r[OUT_W-1:0];
      end
    end
  end

  // Window FSM: idle/count control, bit and ones counters, mode latch.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_state    <= S_IDLE;
      r_bit_cnt  <= '0;
      r_ones_cnt <= '0;
      r_mode     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_bit_cnt  <= '0;
          r_ones_cnt <= '0;
          if (en) begin
            r_state <= S_COUNT;
            r_mode  <= bipolar;
          end
        end
        S_COUNT: begin
          if (!en) begin
            // Abort: the partial window is discarded.
            r_state    <= S_IDLE;
            r_bit_cnt  <= '0;
            r_ones_cnt <= '0;
          end else if (sn_valid) begin
            if (w_last) begin
              // The next valid bit starts a new window immediately.
              r_bit_cnt  <= '0;
              r_ones_cnt <= '0;
              r_mode     <= bipolar;
            end else begin
              r_bit_cnt  <= r_bit_cnt + BIT_ONE;
              r_ones_cnt <= w_total;
            end
          end
        end
        default: begin
          r_state    <= S_IDLE;
          r_bit_cnt  <= '0;
          r_ones_cnt <= '0;
        end
      endcase
    end
  end

  // Output register: load on window end, clear valid on transfer, flag overwrites.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      r_out_data  <= '0;
      r_out_valid <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      if (w_last) begin
        r_out_data  <= w_result;
        r_out_valid <= 1'b1;
        if (r_out_valid && !out_ready) begin
          r_overrun <= 1'b1;
        end
      end else if (r_out_valid && out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_data    = r_out_data;
  assign out_valid   = r_out_valid;
  assign overrun     = r_overrun;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_sn_stream_decoder.sv
// Testbench for sn_stream_decoder with the default parameters (N = 256, 8-bit results).
// Each directed task drives one scenario. Expected results go into exp_q when
// a window is driven. They are popped and compared whenever the consumer
// accepts a result.

`timescale 1ns/1ps

module tb_sn_stream_decoder;

  localparam int W  = 8;
  localparam int OW = 8;
  localparam int N  = 1 << W;

  localparam logic [0:0] S_IDLE  = 1'b0;
  localparam logic [0:0] S_COUNT = 1'b1;

  logic          clk;
  logic          rst;
  logic          en;
  logic          sn_bit;
  logic          sn_valid;
  logic          bipolar;
  logic [OW-1:0] out_data;
  logic          out_valid;
  logic          out_ready;
  logic          overrun;
  logic [0:0]    dbg_state;

  logic [OW-1:0] exp_q[$];
  int            checks;
  int            failures;

  sn_stream_decoder #(.WIN_LOG2(W), .OUT_W(OW)) dut (
    .clk        (clk),
    .rst_n      (rst),
    .en         (en),
    .sn_bit     (sn_bit),
    .sn_valid   (sn_valid),
    .bipolar    (bipolar),
    .out_data   (out_data),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .overrun    (overrun),
    .o_dbg_state(dbg_state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every accepted result must match the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_result got=%h required=none", out_data);
      end else begin
        logic [OW-1:0] e;
        e = exp_q.pop_front();
        if (out_data !== e) begin
          failures++;
          $display("FAIL result got=%h required=%h", out_data, e);
        end
      end
    end
  end

  // Reference decode built from the arithmetic definition of the result.
  function automatic logic [OW-1:0] model(input int total, input bit bip);
    int u;
    int s;
    int r;
    if (!bip) begin
      u = total >> (W - OW);
      if (u == (1 << OW)) u = (1 << OW) - 1;
      return u[OW-1:0];
    end
    s = total - (1 << (W - 1));
    r = s >>> (W - OW);
    if (r > (1 << (OW - 1)) - 1) r = (1 << (OW - 1)) - 1;
    if (r < -(1 << (OW - 1))) r = -(1 << (OW - 1));
    return r[OW-1:0];
  endfunction

  // driver tasks
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_dec();
    en = 1'b1;
    step();
  endtask

  task automatic stop_dec();
    en       = 1'b0;
    sn_valid = 1'b0;
    sn_bit   = 1'b0;
    step();
    step();
  endtask

  // Drive N valid bits. With gaps, every valid bit follows an invalid cycle
  // that carries sn_bit = 1. If tog >= 0, bipolar is flipped after bit tog.
  task automatic send_window(input logic [N-1:0] pat, input bit gaps, input int tog);
    for (int i = 0; i < N; i++) begin
      if (gaps) begin
        sn_valid = 1'b0;
        sn_bit   = 1'b1;
        step();
      end
      sn_valid = 1'b1;
      sn_bit   = pat[i];
      step();
      if (i == tog) bipolar = ~bipolar;
    end
    sn_valid = 1'b0;
    sn_bit   = 1'b0;
  endtask

  function automatic logic [N-1:0] pat_alt();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = ~i[0];
    return p;
  endfunction

  function automatic logic [N-1:0] pat_first(input int k);
    logic [N-1:0] p;
    p = '0;
    for (int i = 0; i < k; i++) p[i] = 1'b1;
    return p;
  endfunction

  task automatic test_reset();
    rst = 1'b1; en = 1'b0; sn_bit = 1'b0; sn_valid = 1'b0; bipolar = 1'b0; out_ready = 1'b1;
    #1;
    checks++;
    if (out_data !== '0 || out_valid !== 1'b0 || overrun !== 1'b0 || dbg_state !== S_IDLE) begin
      failures++;
      $display("FAIL reset_state got=%h/%b/%b/%b required=00/0/0/0", out_data, out_valid, overrun, dbg_state);
    end
    step();
    step();
    #3 rst = 1'b0;
    step();
  endtask

  task automatic test_unipolar_ones();
    int first;
    int second;
    first = -1;
    second = -1;
    bipolar = 1'b0; sn_valid = 1'b1; sn_bit = 1'b1; en = 1'b1;
    exp_q.push_back(8'hFF);
    exp_q.push_back(8'hFF);
    for (int c = 1; c <= 600 && second < 0; c++) begin
      step();
      if (out_valid === 1'b1) begin
        if (first < 0) first = c;
        else if (c > first + 1) second = c;
      end
    end
    checks++;
    if (first !== 257) begin
      failures++;
      $display("FAIL ones_latency got=%0d required=257", first);
    end
    checks++;
    if (second !== 513) begin
      failures++;
      $display("FAIL ones_no_gap got=%0d required=513", second);
    end
    stop_dec();
  endtask

  task automatic test_unipolar_alt();
    bipolar = 1'b0;
    start_dec();
    checks++;
    if (dbg_state !== S_COUNT) begin
      failures++;
      $display("FAIL state_count got=%b required=%b", dbg_state, S_COUNT);
    end
    exp_q.push_back(8'h80);
    send_window(pat_alt(), 1'b0, -1);
    exp_q.push_back(8'h00);
    send_window('0, 1'b0, -1);
    stop_dec();
  endtask

  task automatic test_bipolar();
    bipolar = 1'b1;
    start_dec();
    exp_q.push_back(8'h80);
    send_window('0, 1'b0, -1);
    exp_q.push_back(8'h7F);
    send_window('1, 1'b0, -1);
    exp_q.push_back(8'h00);
    send_window(pat_alt(), 1'b0, -1);
    // bipolar drops mid-window: this window is still bipolar, the next is unipolar
    exp_q.push_back(8'h7F);
    send_window('1, 1'b0, 100);
    exp_q.push_back(8'hFF);
    send_window('1, 1'b0, -1);
    stop_dec();
  endtask

  task automatic test_valid_gaps();
    logic [N-1:0] p;
    for (int i = 0; i < N; i++) p[i] = (i % 4 == 0);
    bipolar = 1'b0;
    start_dec();
    exp_q.push_back(8'h40);
    send_window(p, 1'b1, -1);
    stop_dec();
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    bipolar   = 1'b0;
    start_dec();
    send_window(pat_first(10), 1'b0, -1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd10 || overrun !== 1'b0) begin
      failures++;
      $display("FAIL bp_first got=%b/%h/%b required=1/0a/0", out_valid, out_data, overrun);
    end
    send_window(pat_first(20), 1'b0, -1);
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'd20 || overrun !== 1'b1) begin
      failures++;
      $display("FAIL bp_overwrite got=%b/%h/%b required=1/14/1", out_valid, out_data, overrun);
    end
    exp_q.push_back(8'd20);
    out_ready = 1'b1;
    step();
    checks++;
    if (out_valid !== 1'b0 || overrun !== 1'b1 || out_data !== 8'd20) begin
      failures++;
      $display("FAIL bp_accept got=%b/%b/%h required=0/1/14", out_valid, overrun, out_data);
    end
    stop_dec();
  endtask

  task automatic test_abort_en();
    bipolar = 1'b0;
    start_dec();
    sn_valid = 1'b1;
    sn_bit   = 1'b1;
    for (int i = 0; i < 100; i++) step();
    en = 1'b0;
    sn_valid = 1'b0;
    step();
    checks++;
    if (dbg_state !== S_IDLE || out_valid !== 1'b0) begin
      failures++;
      $display("FAIL abort_idle got=%b/%b required=%b/0", dbg_state, out_valid, S_IDLE);
    end
    start_dec();
    exp_q.push_back(8'h80);
    send_window(pat_alt(), 1'b0, -1);
    stop_dec();
  endtask

  task automatic test_async_reset();
    bipolar = 1'b0;
    start_dec();
    sn_valid = 1'b1;
    sn_bit   = 1'b1;
    for (int i = 0; i < 100; i++) step();
    sn_valid = 1'b0;
    en = 1'b0;
    #2 rst = 1'b1;
    #1;
    checks++;
    if (out_data !== '0 || out_valid !== 1'b0 || overrun !== 1'b0 || dbg_state !== S_IDLE) begin
      failures++;
      $display("FAIL async_reset got=%h/%b/%b/%b required=00/0/0/0", out_data, out_valid, overrun, dbg_state);
    end
    #2 rst = 1'b0;
    step();
    start_dec();
    exp_q.push_back(8'h80);
    send_window(pat_alt(), 1'b0, -1);
    stop_dec();
  endtask

  task automatic test_random();
    logic [N-1:0] p;
    bit bip;
    bit gaps;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < N; i++) p[i] = 1'($urandom_range(0, 1));
      bip  = 1'($urandom_range(0, 1));
      gaps = 1'($urandom_range(0, 1));
      bipolar = bip;
      start_dec();
      exp_q.push_back(model($countones(p), bip));
      send_window(p, gaps, -1);
      stop_dec();
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    test_reset();
    test_unipolar_ones();
    test_unipolar_alt();
    test_bipolar();
    test_valid_gaps();
    test_backpressure();
    test_abort_en();
    test_async_reset();
    test_random();
    step();
    step();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL pending_results got=%0d required=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/sn_stream_decoder.md
Name: sn_stream_decoder

Overview:
Downstream stage of the stochastic multiplier. It consumes the serial stochastic bitstream (XNOR product) and converts it to a binary value by counting ones over a fixed window of valid bits. Windows run back-to-back with no dropped bits. Results are presented on a valid/ready output register with overrun detection. Unipolar and bipolar decoding are both supported.

Parameters:
WIN_LOG2, 8, log2 of window length in valid bits (N = 2^WIN_LOG2); legal range 2..16
OUT_W, 8, result width; must satisfy 2 <= OUT_W <= WIN_LOG2

Ports:
clk  in  1  clock; all state updates on rising edge
rst_n  in  1  reset, asynchronous, active-high despite the name (1 = reset)
en  in  1  1 = decode; 0 = abort window and idle
sn_bit  in  1  stochastic bitstream bit
sn_valid  in  1  sn_bit is sampled only on cycles where sn_valid = 1
bipolar  in  1  0 = unipolar decode, 1 = bipolar decode; latched at window start
out_data  out  OUT_W  decoded result; unsigned (unipolar) or two's complement (bipolar)
out_valid  out  1  out_data holds an unconsumed result
out_ready  in  1  consumer accepts out_data when out_valid & out_ready
overrun  out  1  sticky; a result was overwritten before it was accepted

Behaviour:
- Reset (rst_n = 1, asynchronous) takes effect immediately and sets: state IDLE, bit_cnt = 0, ones_cnt = 0, mode_q = 0, out_data = 0, out_valid = 0, overrun = 0.
- State IDLE: counters are held at 0. If en = 1, go to COUNT and latch mode_q <= bipolar on that same edge. No bits are sampled in the IDLE cycle.
- State COUNT, each edge:
  - if en = 0: go to IDLE and clear both counters; out_data, out_valid and overrun are unchanged.
  - else if sn_valid = 1: bit_cnt += 1 and ones_cnt += sn_bit.
  - else: hold counters.
- Counter widths: bit_cnt is WIN_LOG2 bits and wraps modulo N. ones_cnt is WIN_LOG2+1 bits so it can hold the full count N.
- Window end: the edge where sn_valid = 1 and bit_cnt = N-1. The result is computed from ones_cnt including that final sn_bit (call it total).
  - On the same edge: load out_data, set out_valid = 1, clear both counters, relatch mode_q <= bipolar.
  - The next valid bit starts the next window. No gap cycle; no bit is skipped.
- Latency: out_valid rises on the edge that samples the Nth valid bit, so it is visible in the following cycle.
- Unipolar result: u = total >> (WIN_LOG2 - OUT_W). If u = 2^OUT_W, saturate to 2^OUT_W - 1.
- Bipolar result:
  - s = total - 2^(WIN_LOG2-1), signed, range -N/2..+N/2.
  - r = s >>> (WIN_LOG2 - OUT_W), arithmetic shift.
  - Clamp r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - For the defaults this gives out_data = total - 128, with 256 → 127.
- Output handshake:
  - When out_valid & out_ready & no window end on this edge: out_valid <= 0 next edge; out_data is held.
  - Window end with out_valid = 0, or with out_valid & out_ready: load the new result, out_valid stays or becomes 1, no overrun.
  - Window end with out_valid & !out_ready: overwrite out_data, out_valid stays 1, overrun <= 1.
  - overrun clears only on reset.
- A change of bipolar mid-window has no effect until the next window start.
- An en drop mid-window discards the partial count. When en returns, a fresh window begins.

Test Plan:
- Unipolar all-ones: en=1, bipolar=0, out_ready=1, sn_valid=1, sn_bit=1 for 256 cycles → single out_valid pulse with out_data=0xFF (saturated), first visible 257 cycles after en rises; counting continues with no gap.
- Unipolar alternating 1,0 for 256 valid bits → out_data=0x80; the next window of all zeros → 0x00, with the window boundary exact (no 257th-bit skip).
- Bipolar: all zeros → 0x80 (-128); all ones → 0x7F (clamped); alternating → 0x00. Toggling bipolar mid-window only changes decoding of the following window.
- Valid gaps: sn_valid on every other cycle, sn_bit=1 on 64 of the 256 valid bits, and sn_bit=1 on invalid cycles too → unipolar out_data=0x40 after 512 cycles; invalid bits are ignored.
- Backpressure: out_ready=0 across two windows with counts 10 then 20 → out_data=20, overrun=1, out_valid=1. Then out_ready=1 for one cycle → out_valid=0 next cycle and overrun stays 1.
- Reset/abort: after 100 valid bits, pulse rst_n=1 → all outputs 0 immediately, without waiting for a clock edge. Separately, dropping en after 100 bits then reasserting → the next result reflects only the 256 post-restart bits.
